// File: rtl/neuron_layer_seq.sv
// Sequences one fully-connected layer: fetch each neuron's operand word,
// sample the shared adder sum, activate/saturate and hand the result off.
module neuron_layer_seq #(
   parameter int unsigned NUM_NEURONS = 4,
   parameter int unsigned ADDR_W      = 4,
   parameter int unsigned ACT_MODE    = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              add_valid,
   input  logic [11:0]       adder_sum,
   output logic [7:0]        out_data,
   output logic [ADDR_W-1:0] out_idx,
   output logic              out_valid,
   input  logic              out_ready
);

   localparam int unsigned SUM_W = 12;
   localparam int unsigned OUT_W = 8;
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_NEURONS - 1);

   // Lower clamp: zero for ReLU, most-negative 8-bit value for linear.
   localparam logic signed [SUM_W-1:0] LO_CLAMP =
      (ACT_MODE == 1) ? 12'sd0 : -12'sd128;
   localparam logic signed [SUM_W-1:0] HI_CLAMP = 12'sd127;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_SAMPLE,
      S_OUT,
      S_DONE
   } state_t;

   state_t                    r_state;
   state_t                    w_next;
   logic [ADDR_W-1:0]         r_index;
   logic                      w_hs;
   logic                      w_last;
   logic signed [SUM_W-1:0]   w_sum;
   logic [OUT_W-1:0]          w_act;

   logic                      r_busy;
   logic                      r_done;
   logic                      r_mem_rd;
   logic                      r_add_valid;
   logic                      r_out_valid;
   logic [OUT_W-1:0]          r_out_data;
   logic [ADDR_W-1:0]         r_out_idx;

   assign w_hs   = (r_state == S_OUT) && out_ready;
   assign w_last = (r_index == LAST_IDX);
   assign w_sum  = adder_sum;

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Next-state decode.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (start) w_next = S_FETCH;
         S_FETCH:  w_next = S_SAMPLE;
         S_SAMPLE: w_next = S_OUT;
         S_OUT:    if (w_hs) w_next = w_last ? S_DONE : S_FETCH;
         S_DONE:   w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   // Neuron index: cleared on layer start, advanced on a non-final handshake.
   always_ff @(posedge clk) begin
      if (!rst_n)                           r_index <= '0;
      else if (r_state == S_IDLE && start)  r_index <= '0;
      else if (w_hs && !w_last)             r_index <= r_index + ADDR_W'(1);
   end

   // Activation with 8-bit saturation of the signed adder sum.
   always_comb begin
      w_act = w_sum[OUT_W-1:0];
      if (w_sum > HI_CLAMP)      w_act = HI_CLAMP[OUT_W-1:0];
      else if (w_sum < LO_CLAMP) w_act = LO_CLAMP[OUT_W-1:0];
   end

   // Control strobes registered from the next state so they align with it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_mem_rd    <= 1'b0;
         r_add_valid <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         r_busy      <= (w_next != S_IDLE);
         r_done      <= (w_next == S_DONE);
         r_mem_rd    <= (w_next == S_FETCH);
         r_add_valid <= (w_next == S_SAMPLE);
         r_out_valid <= (w_next == S_OUT);
      end
   end

   // Result capture in SAMPLE; held through OUT until the next capture.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_out_data <= '0;
         r_out_idx  <= '0;
      end else if (r_state == S_SAMPLE) begin
         r_out_data <= w_act;
         r_out_idx  <= r_index;
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign mem_rd    = r_mem_rd;
   assign mem_addr  = r_index;
   assign add_valid = r_add_valid;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_idx   = r_out_idx;

endmodule

// File: doc/neuron_layer_seq.md
Name: neuron_layer_seq

Overview:
- Sequences one fully-connected layer through the shared 8-input + bias 12-bit signed adder.
- For each output neuron it:
  - issues a read of that neuron's operand word (8 products + bias) from operand memory;
  - samples the combinational adder sum on the following cycle;
  - applies activation and 8-bit saturation;
  - hands the result downstream on a valid/ready interface.
- Sits between the layer-start logic and the activation/output buffer.

Parameters:
- NUM_NEURONS, default 4: neurons per layer, legal range 1..2^ADDR_W.
- ADDR_W, default 4: width of the operand-memory address and of out_idx.
- ACT_MODE, default 1: 0 = linear with signed saturation; 1 = ReLU then saturation.

Ports:
- clk, input, 1: system clock, rising edge.
- rst_n, input, 1: reset, synchronous, active-low.
- start, input, 1: layer start request, sampled only in IDLE.
- busy, output, 1: high whenever state != IDLE.
- done, output, 1: one-cycle pulse after the last result handshake.
- mem_rd, output, 1: operand-memory read strobe.
- mem_addr, output, ADDR_W: operand word index, equal to the current neuron index.
- add_valid, output, 1: adder inputs are valid this cycle (memory data present).
- adder_sum, input, 12: signed adder output; combinational from memory data.
- out_data, output, 8: signed activated result.
- out_idx, output, ADDR_W: neuron index of out_data.
- out_valid, output, 1: result valid.
- out_ready, input, 1: downstream accepts.

Behaviour:
- Clocking and reset: one clock. Reset is synchronous, active-low.
  - While rst_n=0 at a rising edge: state <= IDLE, index <= 0.
  - All outputs (busy, done, mem_rd, mem_addr, add_valid, out_data, out_idx, out_valid) read 0 from the cycle after that edge.
  - Reset mid-layer abandons the layer. No done pulse is generated.
- All outputs are registered or decoded from registered state. There is no combinational path from out_ready to any output.
- FSM states: IDLE, FETCH, SAMPLE, OUT, DONE.
- IDLE:
  - start=1 at an edge → FETCH, index <= 0.
  - start has no effect in any other state.
- FETCH:
  - mem_rd=1, mem_addr=index.
  - Always → SAMPLE. Memory read latency is exactly 1 cycle.
- SAMPLE:
  - add_valid=1.
  - At the edge, capture the activated, saturated adder_sum into out_data and index into out_idx.
  - → OUT.
- OUT:
  - out_valid=1; out_data and out_idx are held stable.
  - A handshake occurs when out_valid=1 and out_ready=1 at an edge.
  - On handshake: if index == NUM_NEURONS-1 → DONE; otherwise index <= index+1 and → FETCH.
  - Without handshake: stay in OUT. No memory activity occurs.
- DONE:
  - done=1 for exactly one cycle, busy=1.
  - → IDLE. A start seen in DONE is ignored.
- Activation, applied to s = signed adder_sum in the range −2048..2047:
  - ACT_MODE=0: out = s clamped to [−128, 127].
  - ACT_MODE=1: out = 0 if s < 0, else min(s, 127).
- Timing:
  - start sampled at edge k → FETCH in cycle k+1, SAMPLE in k+2, out_valid first high in k+3.
  - With out_ready held at 1, each neuron costs 3 cycles.
  - A layer costs 3·NUM_NEURONS cycles, plus 1 DONE cycle.
- The index never wraps. The terminal compare uses NUM_NEURONS-1, so NUM_NEURONS = 2^ADDR_W is legal.
- NUM_NEURONS=1 gives the sequence FETCH, SAMPLE, OUT, DONE.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with start=1 → all outputs 0, busy=0. Release → IDLE with no spontaneous activity.
- Full layer: ACT_MODE=1, NUM_NEURONS=4, sums 300, −5, 100, −2048, out_ready=1 →
  - out_data = 127, 0, 100, 0 with out_idx = 0..3;
  - mem_addr = 0..3, each with a one-cycle mem_rd;
  - done pulses 13 cycles after start, then busy=0.
- Linear saturation: ACT_MODE=0, sums −300, 2047, −7, 0 → out_data 0x80, 0x7F, 0xF9, 0x00.
- Backpressure: drop out_ready for 5 cycles during the OUT of neuron 1 → out_valid=1 and out_data/out_idx stay stable; no mem_rd; neuron 2 FETCH occurs the cycle after the handshake.
- Start misuse: pulse start during SAMPLE and during DONE → ignored, exactly 4 results and one done. A start one cycle after done → new layer from index 0.
- Mid-layer reset: assert rst_n=0 for one edge while in OUT for neuron 2 → next cycle out_valid=0 and busy=0 with no done. A new start produces out_idx 0 first.
